// File: rtl/kyber_pkg.sv
// Shared widths and the packed-word payload for the coefficient packing path.
package kyber_pkg;

    localparam int unsigned COEFF_W         = 2;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned COEFFS_PER_WORD = WORD_W / COEFF_W;
    localparam int unsigned CNT_W           = $clog2(COEFFS_PER_WORD + 1);

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [CNT_W-1:0]  count;
        logic              last;
    } packed_word_t;

endpackage

// File: rtl/coeff_packer_if.sv
// Coefficient-in / packed-word-out valid/ready streams of coeff_packer.
interface coeff_packer_if #(
    parameter int unsigned COEFF_W = kyber_pkg::COEFF_W,
    parameter int unsigned WORD_W  = kyber_pkg::WORD_W
);

    localparam int unsigned CNT_W = $clog2(WORD_W / COEFF_W + 1);

    logic               in_valid;
    logic               in_ready;
    logic [COEFF_W-1:0] in_coeff;
    logic               in_last;

    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_word;
    logic [CNT_W-1:0]   out_count;
    logic               out_last;

    // Packer side.
    modport slave (
        input  in_valid, in_coeff, in_last, out_ready,
        output in_ready, out_valid, out_word, out_count, out_last
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_coeff, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_count, out_last
    );

endinterface

// File: rtl/coeff_packer_outreg.sv
// Valid/ready holding register for one packed word; payload is frozen while stalled.
module coeff_packer_outreg
    import kyber_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  packed_word_t i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output packed_word_t o_data
);

    logic         r_valid;
    packed_word_t r_data;

    // Caller only loads when the register is empty or draining this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/coeff_packer.sv
// Packs COEFF_W-bit coefficients LSB-first into WORD_W-bit words with count/last.
// Define COEFF_PACKER_SKID_EN to keep assembling while an output word is pending.
module coeff_packer #(
    parameter int unsigned COEFF_W = kyber_pkg::COEFF_W,
    parameter int unsigned WORD_W  = kyber_pkg::WORD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    coeff_packer_if.slave bus
);
    import kyber_pkg::*;

    localparam int unsigned N     = WORD_W / COEFF_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    // The payload struct is sized by the package, so the instance must agree with it.
    if (COEFF_W != kyber_pkg::COEFF_W || WORD_W != kyber_pkg::WORD_W ||
        N != COEFFS_PER_WORD || (WORD_W % COEFF_W) != 0) begin : g_cfg_check
        $error("coeff_packer: COEFF_W/WORD_W must match kyber_pkg and divide evenly");
    end

    logic [WORD_W-1:0] r_asm;
    logic [IDX_W-1:0]  r_idx;

    logic [WORD_W-1:0] w_asm_ins;
    logic [CNT_W-1:0]  w_count;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_slot_last;
    logic              w_complete;
    logic              w_load;
    logic              w_out_valid;
    packed_word_t      w_load_data;
    packed_word_t      w_out_data;

    // The target slot is still zero since the last clear, so OR-ing inserts it.
    assign w_asm_ins   = r_asm | (WORD_W'(bus.in_coeff) << (32'(r_idx) * COEFF_W));
    assign w_slot_last = (r_idx == IDX_W'(N - 1));
    assign w_count     = CNT_W'(r_idx) + CNT_W'(1);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_complete  = w_accept && (w_slot_last || bus.in_last);

`ifdef COEFF_PACKER_SKID_EN
    logic             r_full;
    logic [CNT_W-1:0] r_hold_count;
    logic             r_hold_last;
    logic             w_out_free;

    assign w_out_free = !w_out_valid || bus.out_ready;
    assign w_in_ready = !r_full;
    assign w_load     = w_out_free && (r_full || w_complete);

    // A held word has priority; no accept can occur while it is held.
    always_comb begin
        w_load_data = '{word: w_asm_ins, count: w_count, last: bus.in_last};
        if (r_full) begin
            w_load_data = '{word: r_asm, count: r_hold_count, last: r_hold_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm        <= '0;
            r_idx        <= '0;
            r_full       <= 1'b0;
            r_hold_count <= '0;
            r_hold_last  <= 1'b0;
        end else if (r_full) begin
            if (w_out_free) begin
                r_full <= 1'b0;
                r_asm  <= '0;
            end
        end else if (w_accept) begin
            if (!w_complete) begin
                r_asm <= w_asm_ins;
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= '0;
                if (w_out_free) begin
                    r_asm <= '0;
                end else begin
                    // Output busy and not draining: park the finished word here.
                    r_asm        <= w_asm_ins;
                    r_full       <= 1'b1;
                    r_hold_count <= w_count;
                    r_hold_last  <= bus.in_last;
                end
            end
        end
    end
`else
    assign w_in_ready  = !w_out_valid;
    assign w_load      = w_complete;
    assign w_load_data = '{word: w_asm_ins, count: w_count, last: bus.in_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_asm <= '0;
                r_idx <= '0;
            end else begin
                r_asm <= w_asm_ins;
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end
`endif

    coeff_packer_outreg u_outreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_word  = w_out_data.word;
    assign bus.out_count = w_out_data.count;
    assign bus.out_last  = w_out_data.last;

endmodule

// File: tb/tb_coeff_packer.sv
// Self-checking bench for coeff_packer: queue-based reference model plus directed literals.
module tb_coeff_packer;
    import kyber_pkg::*;

    localparam int unsigned N = COEFFS_PER_WORD;

    logic clk = 1'b0;
    logic rst_n;

    coeff_packer_if bus ();

    coeff_packer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int unsigned  acc_cnt   = 0;
    int unsigned  words_exp = 0;
    packed_word_t exp_q[$];
    packed_word_t got_q[$];
    logic [WORD_W-1:0] part_word = '0;
    int unsigned  part_n  = 0;
    logic         stalled = 1'b0;
    packed_word_t held    = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic packed_word_t got_at(input int unsigned i);
        packed_word_t z;
        z = '0;
        if (i < got_q.size()) z = got_q[i];
        return z;
    endfunction

    // Model: expected words in order; the output shows the head, in_ready follows occupancy.
    always @(negedge clk) begin : compare
        logic         exp_rdy;
        packed_word_t cur;
        cur = '{word: bus.out_word, count: bus.out_count, last: bus.out_last};
        if (!rst_n) begin
            chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
            chk("rst_out_word",  64'(bus.out_word),  64'(0));
            chk("rst_out_count", 64'(bus.out_count), 64'(0));
            chk("rst_out_last",  64'(bus.out_last),  64'(0));
            chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
            exp_q.delete();
            part_word = '0;
            part_n    = 0;
            stalled   = 1'b0;
        end else begin
            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_word",  64'(bus.out_word),  64'(exp_q[0].word));
                chk("out_count", 64'(bus.out_count), 64'(exp_q[0].count));
                chk("out_last",  64'(bus.out_last),  64'(exp_q[0].last));
            end
            if (stalled) chk("stall_hold", 64'(cur), 64'(held));
`ifdef COEFF_PACKER_SKID_EN
            exp_rdy = (exp_q.size() < 2);
`else
            exp_rdy = (exp_q.size() == 0);
`endif
            chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            stalled = bus.out_valid && !bus.out_ready;
            held    = cur;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(cur);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                part_word = part_word | (WORD_W'(bus.in_coeff) << (COEFF_W * part_n));
                part_n++;
                if (part_n == N || bus.in_last) begin
                    exp_q.push_back('{word: part_word, count: CNT_W'(part_n), last: bus.in_last});
                    words_exp++;
                    part_word = '0;
                    part_n    = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [COEFF_W-1:0] c, input logic l);
        int unsigned c0;
        int unsigned n;
        c0 = acc_cnt;
        n  = 0;
        bus.in_valid = 1'b1;
        bus.in_coeff = c;
        bus.in_last  = l;
        do begin
            tick();
            n++;
        end while (acc_cnt == c0 && n < 200);
        if (acc_cnt == c0) begin
            bad++;
            total++;
            $display("FAIL send_timeout: got=no accept expected=accept at %0t", $time);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_now_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_now_word",  64'(bus.out_word),  64'(0));
        chk("rst_now_count", 64'(bus.out_count), 64'(0));
        chk("rst_now_last",  64'(bus.out_last),  64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #(3_000_000);
        $display("FAIL watchdog: got=timeout expected=finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned c0;
        int unsigned w0;
        int unsigned cyc;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_coeff  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // Full word of 0,1,2,3 repeating.
        got_q.delete();
        for (int i = 0; i < 16; i++) send(COEFF_W'(i % 4), 1'b0);
        @(negedge clk);
        chk("t1_latency_valid", 64'(bus.out_valid), 64'(1));
        tick();
        tick();
        chk("t1_words", 64'(got_q.size()), 64'(1));
        chk("t1_word",  64'(got_at(0).word),  64'h0000_0000_E4E4_E4E4);
        chk("t1_count", 64'(got_at(0).count), 64'(16));
        chk("t1_last",  64'(got_at(0).last),  64'(0));

        // Short polynomial, then a one-coefficient word starting at slot 0.
        got_q.delete();
        send(2'd3, 1'b0);
        send(2'd3, 1'b0);
        send(2'd3, 1'b1);
        send(2'd1, 1'b1);
        repeat (3) tick();
        chk("t2_words",   64'(got_q.size()), 64'(2));
        chk("t2_word",    64'(got_at(0).word),  64'h3F);
        chk("t2_count",   64'(got_at(0).count), 64'(3));
        chk("t2_last",    64'(got_at(0).last),  64'(1));
        chk("t2b_word",   64'(got_at(1).word),  64'h1);
        chk("t2b_count",  64'(got_at(1).count), 64'(1));

        // in_last on the final slot gives exactly one word.
        got_q.delete();
        for (int i = 0; i < 16; i++) send(2'd2, 1'(i == 15));
        repeat (4) tick();
        chk("t3_words", 64'(got_q.size()), 64'(1));
        chk("t3_word",  64'(got_at(0).word),  64'hAAAA_AAAA);
        chk("t3_count", 64'(got_at(0).count), 64'(16));
        chk("t3_last",  64'(got_at(0).last),  64'(1));

        // Back-pressure with the output stalled.
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(2'd1, 1'b0);
        tick();
        tick();
`ifdef COEFF_PACKER_SKID_EN
        chk("t4_ready_pending", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < 16; i++) send(2'd2, 1'b0);
        chk("t4_ready_full", 64'(bus.in_ready), 64'(0));
`else
        chk("t4_ready_pending", 64'(bus.in_ready), 64'(0));
`endif
        c0 = acc_cnt;
        bus.in_valid = 1'b1;
        bus.in_coeff = 2'd3;
        repeat (5) tick();
        bus.in_valid = 1'b0;
        chk("t4_blocked", 64'(acc_cnt - c0), 64'(0));
        bus.out_ready = 1'b1;
`ifndef COEFF_PACKER_SKID_EN
        for (int i = 0; i < 16; i++) send(2'd2, 1'b0);
`endif
        repeat (4) tick();
        chk("t4_words",  64'(got_q.size()), 64'(2));
        chk("t4_word0",  64'(got_at(0).word), 64'h5555_5555);
        chk("t4_word1",  64'(got_at(1).word), 64'hAAAA_AAAA);
        chk("t4_count1", 64'(got_at(1).count), 64'(16));

        // Reset with a pending word, then with a partial word.
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(2'd3, 1'b0);
        chk("t5_pre_valid", 64'(bus.out_valid), 64'(1));
        rst_pulse();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(2'd3, 1'b0);
        rst_pulse();
        for (int i = 0; i < 16; i++) send(2'd1, 1'b0);
        repeat (3) tick();
        chk("t5_words", 64'(got_q.size()), 64'(1));
        chk("t5_word",  64'(got_at(0).word),  64'h5555_5555);
        chk("t5_count", 64'(got_at(0).count), 64'(16));
        chk("t5_last",  64'(got_at(0).last),  64'(0));

        // Random valid/ready traffic over 1000 accepted coefficients.
        got_q.delete();
        w0  = words_exp;
        c0  = acc_cnt;
        cyc = 0;
        while ((acc_cnt - c0) < 1000 && cyc < 20000) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_coeff  = COEFF_W'($urandom);
            bus.in_last   = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_accepts", 64'((acc_cnt - c0) >= 1000), 64'(1));
        send(2'd2, 1'b1);
        repeat (6) tick();
        chk("rand_word_total", 64'(got_q.size()), 64'(words_exp - w0));
        chk("rand_drained",    64'(bus.out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
